// File: rtl/combo_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lane_array
//  Description : Multi-lane combo sprite animator. Each lane runs its own
//                grow / shrink / hold / launch sequence on the frame clock and
//                drives sprite position, size and audio flags. A saturating
//                combo counter tallies HOLD->LAUNCH transitions.
//                Optional macro COMBO_KEY_LAUNCH_EN lets K_Press launch held
//                sprites in addition to the beat frame.
//  Revision    : 1.0 - initial multi-lane release
// ============================================================================
module combo_lane_array #(
    parameter int         LANES        = 4,
    parameter int         X_BASE       = 260,
    parameter int         X_STEP       = 40,
    parameter int         Y_CENTER     = 288,
    parameter int         SIZE_MAX     = 50,
    parameter int         SIZE_MIN     = 20,
    parameter int         SIZE_HOLD    = 40,
    parameter int         LAUNCH_SPEED = 20,
    parameter int         Y_TOP        = 10,
    parameter logic [3:0] LAUNCH_FRAME = 4'hE
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [LANES-1:0]      lane_en,
    input  logic                  K_Press,
    input  logic [3:0]            frame,
    input  logic                  combo_clr,
    output logic [10*LANES-1:0]   BallX,
    output logic [10*LANES-1:0]   BallY,
    output logic [10*LANES-1:0]   BallS,
    output logic [LANES-1:0]      keep_on,
    output logic [LANES-1:0]      activate,
    output logic [LANES-1:0]      audio_flag,
    output logic [7:0]            combo_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GROW   = 3'd1,
        ST_SHRINK = 3'd2,
        ST_HOLD   = 3'd3,
        ST_LAUNCH = 3'd4,
        ST_RETIRE = 3'd5
    } lane_state_t;

    localparam logic [9:0] C_Y_CENTER     = 10'(Y_CENTER);
    localparam logic [9:0] C_Y_TOP        = 10'(Y_TOP);
    localparam logic [9:0] C_Y_LIMIT      = 10'(Y_TOP + LAUNCH_SPEED);
    localparam logic [9:0] C_LAUNCH_SPEED = 10'(LAUNCH_SPEED);
    localparam logic [9:0] C_SIZE_MAX     = 10'(SIZE_MAX);
    localparam logic [9:0] C_SIZE_MIN     = 10'(SIZE_MIN);
    localparam logic [9:0] C_SIZE_HOLD    = 10'(SIZE_HOLD);

    // Key launch qualifier: only live when the key feature is compiled in
    logic w_key;
`ifdef COMBO_KEY_LAUNCH_EN
    assign w_key = K_Press;
`else
    logic w_unused_key;
    assign w_unused_key = K_Press;
    assign w_key        = 1'b0;
`endif

    // One bit per lane that is leaving HOLD for LAUNCH on the coming edge;
    // the same term drives both the lane FSM and the combo counter so a
    // simultaneous key hit and beat frame can only count once.
    logic [LANES-1:0] w_launch;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [9:0] C_X = 10'(X_BASE + gi * X_STEP);

            lane_state_t r_state;
            logic [9:0]  r_y;
            logic [9:0]  r_s;

            assign w_launch[gi] = (r_state == ST_HOLD) &&
                                  ((frame == LAUNCH_FRAME) || w_key);

            // Lane sprite sequencer: state, Y position and size
            always_ff @(posedge frame_clk) begin
                if (Reset) begin
                    r_state <= ST_IDLE;
                    r_y     <= C_Y_CENTER;
                    r_s     <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_y <= C_Y_CENTER;
                            r_s <= '0;
                            if (lane_en[gi]) r_state <= ST_GROW;
                        end
                        ST_GROW: begin
                            if (r_s < C_SIZE_MAX) r_s     <= r_s + 10'd1;
                            else                  r_state <= ST_SHRINK;
                        end
                        ST_SHRINK: begin
                            if (r_s > C_SIZE_MIN) begin
                                r_s <= r_s - 10'd1;
                            end else begin
                                r_s     <= C_SIZE_HOLD;
                                r_state <= ST_HOLD;
                            end
                        end
                        ST_HOLD: begin
                            r_s <= C_SIZE_HOLD;
                            if (w_launch[gi]) r_state <= ST_LAUNCH;
                        end
                        ST_LAUNCH: begin
                            // Compare against top+speed so the subtraction
                            // can never wrap below Y_TOP.
                            if (r_y > C_Y_LIMIT) begin
                                r_y <= r_y - C_LAUNCH_SPEED;
                            end else begin
                                r_y     <= C_Y_TOP;
                                r_state <= ST_RETIRE;
                            end
                        end
                        ST_RETIRE: begin
                            r_state <= ST_IDLE;
                            r_y     <= C_Y_CENTER;
                            r_s     <= '0;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_y     <= C_Y_CENTER;
                            r_s     <= '0;
                        end
                    endcase
                end
            end

            assign BallX[10*gi +: 10] = C_X;
            assign BallY[10*gi +: 10] = r_y;
            assign BallS[10*gi +: 10] = r_s;
            assign keep_on[gi]        = (r_state != ST_IDLE);
            assign activate[gi]       = (r_state == ST_HOLD) || (r_state == ST_LAUNCH);
            assign audio_flag[gi]     = (r_state == ST_LAUNCH);
        end
    endgenerate

    // Count lanes launching this edge and form the widened combo sum
    logic [3:0] w_launch_cnt;
    logic [8:0] w_combo_sum;
    logic [7:0] r_combo;

    always_comb begin
        w_launch_cnt = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            w_launch_cnt = w_launch_cnt + 4'(w_launch[i]);
        end
        w_combo_sum = {1'b0, r_combo} + 9'(w_launch_cnt);
    end

    // Saturating combo counter; clear wins over same-cycle launches
    always_ff @(posedge frame_clk) begin
        if (Reset || combo_clr) begin
            r_combo <= 8'd0;
        end else if (w_combo_sum > 9'd255) begin
            r_combo <= 8'd255;
        end else begin
            r_combo <= w_combo_sum[7:0];
        end
    end

    assign combo_count = r_combo;

endmodule
`default_nettype wire

// File: tb/tb_combo_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_lane_array
//  Description : Directed self-checking bench for combo_lane_array (4 lanes,
//                default parameters). Honours COMBO_KEY_LAUNCH_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lane_array;

    localparam int LANES = 4;

    logic                  frame_clk;
    logic                  Reset;
    logic [LANES-1:0]      lane_en;
    logic                  K_Press;
    logic [3:0]            frame;
    logic                  combo_clr;
    logic [10*LANES-1:0]   BallX;
    logic [10*LANES-1:0]   BallY;
    logic [10*LANES-1:0]   BallS;
    logic [LANES-1:0]      keep_on;
    logic [LANES-1:0]      activate;
    logic [LANES-1:0]      audio_flag;
    logic [7:0]            combo_count;

    int checks = 0;
    int errors = 0;

    combo_lane_array #(.LANES(LANES)) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .lane_en     (lane_en),
        .K_Press     (K_Press),
        .frame       (frame),
        .combo_clr   (combo_clr),
        .BallX       (BallX),
        .BallY       (BallY),
        .BallS       (BallS),
        .keep_on     (keep_on),
        .activate    (activate),
        .audio_flag  (audio_flag),
        .combo_count (combo_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] lx(input int i);
        return BallX[10*i +: 10];
    endfunction
    function automatic logic [9:0] ly(input int i);
        return BallY[10*i +: 10];
    endfunction
    function automatic logic [9:0] ls(input int i);
        return BallS[10*i +: 10];
    endfunction

    // Bounded wait until every lane in mask shows activate
    task automatic wait_hold(input logic [LANES-1:0] mask);
        int n = 0;
        while (((activate & mask) != mask) && (n < 200)) begin
            tick();
            n++;
        end
        check("wait_hold", 32'(activate & mask), 32'(mask));
    endtask

    // Bounded wait until all lanes are back in IDLE
    task automatic wait_idle();
        int n = 0;
        while ((keep_on != '0) && (n < 60)) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(keep_on), 32'd0);
    endtask

    // Start lanes in mask, bring them to HOLD, then launch on the beat frame
    task automatic run_round(input logic [LANES-1:0] mask, input logic clr);
        lane_en = mask;
        tick();
        lane_en = '0;
        wait_hold(mask);
        frame     = 4'hE;
        combo_clr = clr;
        tick();
        frame     = 4'h0;
        combo_clr = 1'b0;
        check("round_audio", 32'(audio_flag), 32'(mask));
    endtask

    initial begin
        Reset     = 1'b1;
        lane_en   = '0;
        K_Press   = 1'b0;
        frame     = 4'h0;
        combo_clr = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        // ---- reset state ----
        for (int i = 0; i < LANES; i++) begin
            check("rst_x", 32'(lx(i)), 32'(260 + 40 * i));
            check("rst_y", 32'(ly(i)), 32'd288);
            check("rst_s", 32'(ls(i)), 32'd0);
        end
        check("rst_keep",  32'(keep_on),     32'd0);
        check("rst_act",   32'(activate),    32'd0);
        check("rst_audio", 32'(audio_flag),  32'd0);
        check("rst_combo", 32'(combo_count), 32'd0);

        // ---- lane 0 size sequence ----
        lane_en = 4'b0001;
        tick();
        lane_en = '0;
        check("grow_s0",   32'(ls(0)),      32'd0);
        check("grow_keep", 32'(keep_on),    32'b0001);
        for (int k = 1; k <= 50; k++) begin
            tick();
            check("grow_s", 32'(ls(0)), 32'(k));
        end
        tick();
        check("peak_s", 32'(ls(0)), 32'd50);
        for (int k = 49; k >= 20; k--) begin
            tick();
            check("shrink_s", 32'(ls(0)), 32'(k));
            check("shrink_act", 32'(activate), 32'd0);
        end
        tick();
        check("hold_s",    32'(ls(0)),      32'd40);
        check("hold_act",  32'(activate),   32'b0001);
        check("hold_keep", 32'(keep_on),    32'b0001);
        // lane_en in HOLD must not retrigger
        lane_en = 4'b0001;
        tick();
        lane_en = '0;
        check("hold_stay_s", 32'(ls(0)),     32'd40);
        check("hold_stay_a", 32'(activate),  32'b0001);
        check("hold_noaud",  32'(audio_flag), 32'd0);

        // ---- lane 0 launch ----
        frame = 4'hE;
        tick();
        frame = 4'h0;
        check("launch_y0",    32'(ly(0)),       32'd288);
        check("launch_audio", 32'(audio_flag),  32'b0001);
        check("launch_combo", 32'(combo_count), 32'd1);
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("launch_y", 32'(ly(0)), 32'(288 - 20 * k));
            check("launch_aud", 32'(audio_flag), 32'b0001);
        end
        tick();
        check("retire_y",     32'(ly(0)),      32'd10);
        check("retire_audio", 32'(audio_flag), 32'd0);
        check("retire_act",   32'(activate),   32'd0);
        check("retire_keep",  32'(keep_on),    32'b0001);
        tick();
        check("idle_y",     32'(ly(0)),       32'd288);
        check("idle_s",     32'(ls(0)),       32'd0);
        check("idle_keep",  32'(keep_on),     32'd0);
        check("idle_combo", 32'(combo_count), 32'd1);

        // ---- drive combo to 253 with four-lane rounds ----
        for (int r = 1; r <= 63; r++) begin
            run_round(4'hF, 1'b0);
            check("round_combo", 32'(combo_count), 32'(1 + 4 * r));
            wait_idle();
        end

        // ---- saturation: 253 + 4 -> 255 ----
        run_round(4'hF, 1'b0);
        check("sat_combo", 32'(combo_count), 32'd255);
        wait_idle();
        run_round(4'hF, 1'b0);
        check("sat_hold", 32'(combo_count), 32'd255);
        wait_idle();

        // ---- clear wins over same-cycle launches ----
        run_round(4'hF, 1'b1);
        check("clr_combo", 32'(combo_count), 32'd0);
        wait_idle();
        check("clr_stays", 32'(combo_count), 32'd0);

        // ---- reset during launch on lane 1 ----
        run_round(4'b0010, 1'b0);
        check("l1_y0",    32'(ly(1)),       32'd288);
        check("l1_combo", 32'(combo_count), 32'd1);
        for (int k = 0; k < 7; k++) tick();
        check("l1_y148", 32'(ly(1)), 32'd148);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst_y",     32'(ly(1)),       32'd288);
        check("mrst_s",     32'(ls(1)),       32'd0);
        check("mrst_keep",  32'(keep_on),     32'd0);
        check("mrst_act",   32'(activate),    32'd0);
        check("mrst_audio", 32'(audio_flag),  32'd0);
        check("mrst_combo", 32'(combo_count), 32'd0);
        tick();
        check("mrst_idle",  32'(keep_on),     32'd0);

        // ---- key press in HOLD at a non-launch frame ----
        lane_en = 4'b0001;
        tick();
        lane_en = '0;
        wait_hold(4'b0001);
        frame   = 4'h3;
        K_Press = 1'b1;
        tick();
        K_Press = 1'b0;
`ifdef COMBO_KEY_LAUNCH_EN
        check("key_audio", 32'(audio_flag),  32'b0001);
        check("key_combo", 32'(combo_count), 32'd1);
        frame = 4'h0;
        wait_idle();
        // key and beat frame together count once
        lane_en = 4'b0001;
        tick();
        lane_en = '0;
        wait_hold(4'b0001);
        frame   = 4'hE;
        K_Press = 1'b1;
        tick();
        K_Press = 1'b0;
        frame   = 4'h0;
        check("keyfrm_audio", 32'(audio_flag),  32'b0001);
        check("keyfrm_combo", 32'(combo_count), 32'd2);
        wait_idle();
`else
        check("nokey_audio", 32'(audio_flag),  32'd0);
        check("nokey_act",   32'(activate),    32'b0001);
        check("nokey_combo", 32'(combo_count), 32'd0);
        frame = 4'hE;
        tick();
        frame = 4'h0;
        check("frm_audio", 32'(audio_flag),  32'b0001);
        check("frm_combo", 32'(combo_count), 32'd1);
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
